// File: rtl/seq_shift_add_mul.sv
// Sequential unsigned shift-and-add multiplier: one WIDTH-bit add/shift step per clock.
// Optional macro MUL_EARLY_EXIT_EN: zero operands complete in one cycle without entering RUN.
module seq_shift_add_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     m_q;
  logic [WIDTH-1:0]     phi_q;
  logic [WIDTH-1:0]     plo_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   prod_q;

  logic [WIDTH:0]       sum_d;
  logic [2*WIDTH-1:0]   shift_d;
  logic                 last_d;
  logic                 skip_d;

  always_comb begin
    sum_d   = plo_q[0] ? ({1'b0, phi_q} + {1'b0, m_q}) : {1'b0, phi_q};
    // {C,S,P_lo} >> 1 keeps the carry as the new MSB and drops P_lo[0]
    shift_d = {sum_d, plo_q[WIDTH-1:1]};
    last_d  = (cnt_q == CW'(WIDTH - 1));
  end

`ifdef MUL_EARLY_EXIT_EN
  assign skip_d = (A == '0) || (B == '0);
`else
  assign skip_d = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            m_q   <= A;
            phi_q <= '0;
            plo_q <= B;
            cnt_q <= '0;
            if (skip_d) begin
              prod_q  <= '0;
              state_q <= S_DONE;
            end else begin
              state_q <= S_RUN;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          {phi_q, plo_q} <= shift_d;
          cnt_q          <= cnt_q + CW'(1);
          if (last_d) begin
            prod_q  <= shift_d;
            state_q <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    Busy    = (state_q == S_RUN);
    Done    = (state_q == S_DONE);
    Product = prod_q;
  end

endmodule
